// File: rtl/led_sequencer.sv
// led_sequencer: drives the NUM_LEDS board LEDs through one of four display
// modes (off, Gray-code count, bounce scan, PWM breathe). A LOG2DELAY-bit
// prescaler sets the pattern step rate. Mode changes arrive on a valid/ready
// command port and pass through a one-cycle LOAD state that restarts the pattern.
// Optional build macro LED_SEQ_PAUSE_EN adds a 'pause' input that freezes
// the prescaler and pattern state. BREATHE keeps its PWM carrier running while paused.
module led_sequencer #(
    parameter int NUM_LEDS  = 5,
    parameter int LOG2DELAY = 22,
    parameter int PWM_BITS  = 4
) (
    input  logic                clk,
    input  logic                rst,
`ifdef LED_SEQ_PAUSE_EN
    input  logic                pause,
`endif
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    output logic [NUM_LEDS-1:0] leds,
    output logic                step_strobe,
    output logic [1:0]          cur_mode
);

    localparam int POS_W = $clog2(NUM_LEDS);

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_GRAY    = 2'd1;
    localparam logic [1:0] MODE_SCAN    = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    localparam logic [POS_W-1:0]     POS_LAST = POS_W'(NUM_LEDS - 1);
    localparam logic [POS_W-1:0]     POS_PREV = POS_W'(NUM_LEDS - 2);
    localparam logic [LOG2DELAY-1:0] PRE_MAX  = '1;
    localparam logic [PWM_BITS-1:0]  LVL_MAX  = '1;

    typedef enum logic {RUN, LOAD} state_t;

    state_t                state, state_next;
    logic [1:0]            mode_latched, mode_latched_next;
    logic [1:0]            cur_mode_next;
    logic [LOG2DELAY-1:0]  prescaler, prescaler_next;
    logic [NUM_LEDS-1:0]   step, step_next;
    logic [POS_W-1:0]      pos, pos_next;
    logic                  dir_down, dir_down_next;
    logic [PWM_BITS-1:0]   level, level_next;
    logic                  level_down, level_down_next;
    logic [PWM_BITS-1:0]   pwm_cnt, pwm_cnt_next;
    logic [NUM_LEDS-1:0]   leds_next;
    logic                  step_strobe_next;
    logic                  tick;
    logic                  hold;

`ifdef LED_SEQ_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    function automatic logic [NUM_LEDS-1:0] gray_of(input logic [NUM_LEDS-1:0] v);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [NUM_LEDS-1:0] onehot_of(input logic [POS_W-1:0] p);
        return {{(NUM_LEDS-1){1'b0}}, 1'b1} << p;
    endfunction

    assign cmd_ready = (state == RUN);

    // Next-state logic: command accept, prescaler, pattern advance and LED drive
    always_comb begin
        state_next        = state;
        mode_latched_next = mode_latched;
        cur_mode_next     = cur_mode;
        prescaler_next    = prescaler;
        step_next         = step;
        pos_next          = pos;
        dir_down_next     = dir_down;
        level_next        = level;
        level_down_next   = level_down;
        pwm_cnt_next      = pwm_cnt + 1'b1;
        leds_next         = leds;
        step_strobe_next  = 1'b0;
        tick              = 1'b0;

        case (state)
            RUN: begin
                if (cmd_valid) begin
                    // Command beats a coincident tick; LOAD clears everything anyway
                    mode_latched_next = cmd_mode;
                    state_next        = LOAD;
                end else begin
                    if (!hold) begin
                        prescaler_next = prescaler + 1'b1;
                    end
                    tick = !hold && (prescaler == PRE_MAX);

                    if (tick && (cur_mode != MODE_OFF)) begin
                        step_strobe_next = 1'b1;
                        case (cur_mode)
                            MODE_GRAY: begin
                                step_next = step + 1'b1;
                            end
                            MODE_SCAN: begin
                                if (!dir_down) begin
                                    if (pos == POS_LAST) begin
                                        dir_down_next = 1'b1;
                                        pos_next      = POS_PREV;
                                    end else begin
                                        pos_next = pos + 1'b1;
                                    end
                                end else begin
                                    if (pos == '0) begin
                                        dir_down_next = 1'b0;
                                        pos_next      = POS_W'(1);
                                    end else begin
                                        pos_next = pos - 1'b1;
                                    end
                                end
                            end
                            MODE_BREATHE: begin
                                if (!level_down) begin
                                    if (level == LVL_MAX) begin
                                        level_down_next = 1'b1;
                                        level_next      = LVL_MAX - 1'b1;
                                    end else begin
                                        level_next = level + 1'b1;
                                    end
                                end else begin
                                    if (level == '0) begin
                                        level_down_next = 1'b0;
                                        level_next      = PWM_BITS'(1);
                                    end else begin
                                        level_next = level - 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end

                    case (cur_mode)
                        MODE_GRAY:    leds_next = gray_of(step_next);
                        MODE_SCAN:    leds_next = onehot_of(pos_next);
                        MODE_BREATHE: leds_next = {NUM_LEDS{pwm_cnt_next < level_next}};
                        default:      leds_next = '0;
                    endcase
                end
            end

            LOAD: begin
                cur_mode_next   = mode_latched;
                prescaler_next  = '0;
                step_next       = '0;
                pos_next        = '0;
                dir_down_next   = 1'b0;
                level_next      = '0;
                level_down_next = 1'b0;
                pwm_cnt_next    = '0;
                leds_next       = '0;
                state_next      = RUN;
            end

            default: state_next = RUN;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            mode_latched <= MODE_OFF;
            cur_mode     <= MODE_OFF;
            prescaler    <= '0;
            step         <= '0;
            pos          <= '0;
            dir_down     <= 1'b0;
            level        <= '0;
            level_down   <= 1'b0;
            pwm_cnt      <= '0;
            leds         <= '0;
            step_strobe  <= 1'b0;
        end else begin
            state        <= state_next;
            mode_latched <= mode_latched_next;
            cur_mode     <= cur_mode_next;
            prescaler    <= prescaler_next;
            step         <= step_next;
            pos          <= pos_next;
            dir_down     <= dir_down_next;
            level        <= level_next;
            level_down   <= level_down_next;
            pwm_cnt      <= pwm_cnt_next;
            leds         <= leds_next;
            step_strobe  <= step_strobe_next;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed bench for led_sequencer. Instance 'dut' runs
// with LOG2DELAY=3 for the GRAY, SCAN, collision, reset and pause sequences.
// Instance 'dut_b' runs with LOG2DELAY=5, which holds each brightness level
// long enough to observe one full 16-cycle PWM period.
module tb_led_sequencer;

    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid, cmd_valid_b;
    logic [1:0]   cmd_mode, cmd_mode_b;
    logic         cmd_ready, cmd_ready_b;
    logic         step_strobe, step_strobe_b;
    logic [N-1:0] leds, leds_b;
    logic [1:0]   cur_mode, cur_mode_b;
`ifdef LED_SEQ_PAUSE_EN
    logic         pause, pause_b;
`endif

    int tests  = 0;
    int errors = 0;

    logic [N-1:0] gray_tbl [8] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110,
                                   5'b00111, 5'b00101, 5'b00100, 5'b01100};
    logic [N-1:0] scan_tbl [9] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000,
                                   5'b01000, 5'b00100, 5'b00010, 5'b00001,
                                   5'b00010};

    always #5 clk = ~clk;

    led_sequencer #(.NUM_LEDS(N), .LOG2DELAY(3), .PWM_BITS(4)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef LED_SEQ_PAUSE_EN
        .pause       (pause),
`endif
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_mode    (cmd_mode),
        .leds        (leds),
        .step_strobe (step_strobe),
        .cur_mode    (cur_mode)
    );

    led_sequencer #(.NUM_LEDS(N), .LOG2DELAY(5), .PWM_BITS(4)) dut_b (
        .clk         (clk),
        .rst         (rst),
`ifdef LED_SEQ_PAUSE_EN
        .pause       (pause_b),
`endif
        .cmd_valid   (cmd_valid_b),
        .cmd_ready   (cmd_ready_b),
        .cmd_mode    (cmd_mode_b),
        .leds        (leds_b),
        .step_strobe (step_strobe_b),
        .cur_mode    (cur_mode_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts negedges up to and including the one showing a strobe (bounded)
    task automatic wait_strobe(input bit sel, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel ? step_strobe_b : step_strobe) && n < 200);
    endtask

    task automatic send_cmd(input logic [1:0] m);
        cmd_mode  = m;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("accept_ready_low", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("load_cur_mode", cur_mode, m);
        check("load_leds", leds, '0);
        check("load_strobe", step_strobe, 1'b0);
        check("run_ready_high", cmd_ready, 1'b1);
    endtask

    task automatic send_cmd_b(input logic [1:0] m);
        cmd_mode_b  = m;
        cmd_valid_b = 1'b1;
        @(negedge clk);
        check("b_accept_ready_low", cmd_ready_b, 1'b0);
        cmd_valid_b = 1'b0;
        @(negedge clk);
        check("b_load_cur_mode", cur_mode_b, m);
        check("b_load_leds", leds_b, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt;
        int full;
        int mixed;
        int lvl;

        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_mode    = 2'd0;
        cmd_valid_b = 1'b0;
        cmd_mode_b  = 2'd0;
`ifdef LED_SEQ_PAUSE_EN
        pause       = 1'b0;
        pause_b     = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_leds", leds, '0);
        check("rst_strobe", step_strobe, 1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_cur_mode", cur_mode, 2'd0);
        rst = 1'b0;

        // OFF after reset: no strobes, dark LEDs
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_strobe || leds != '0) cnt++;
        end
        check("off_quiet", cnt, 0);

        // GRAY: strobe every 8 clocks, Gray sequence, wrap after 32 steps
        send_cmd(2'd1);
        for (int k = 1; k <= 32; k++) begin
            wait_strobe(1'b0, n);
            check("gray_gap", n, 8);
            if (k <= 8) check("gray_leds", leds, gray_tbl[k-1]);
            if (k == 31) check("gray_step31", leds, 5'b10000);
            if (k == 32) check("gray_wrap", leds, 5'b00000);
        end

        // SCAN: bounce without repeated endpoints, period 8 ticks
        send_cmd(2'd2);
        @(negedge clk);
        check("scan_start", leds, 5'b00001);
        for (int k = 1; k <= 9; k++) begin
            wait_strobe(1'b0, n);
            check("scan_gap", n, (k == 1) ? 7 : 8);
            check("scan_leds", leds, scan_tbl[k-1]);
        end

        // Command lands on the tick edge (prescaler=7): tick dropped, LOAD taken
        repeat (7) @(negedge clk);
        check("pre_collide_strobe", step_strobe, 1'b0);
        cmd_mode  = 2'd1;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("collide_strobe", step_strobe, 1'b0);
        check("collide_ready", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("collide_cur_mode", cur_mode, 2'd1);
        check("collide_leds", leds, 5'b00000);
        wait_strobe(1'b0, n);
        check("collide_gap", n, 8);
        check("collide_first_leds", leds, 5'b00001);

        // Reset in the middle of SCAN at pos=3
        send_cmd(2'd2);
        for (int k = 1; k <= 3; k++) begin
            wait_strobe(1'b0, n);
        end
        check("scan_pos3", leds, 5'b01000);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_leds", leds, '0);
        check("midrst_cur_mode", cur_mode, 2'd0);
        check("midrst_ready", cmd_ready, 1'b1);
        check("midrst_strobe", step_strobe, 1'b0);
        rst = 1'b0;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (step_strobe || leds != '0) cnt++;
        end
        check("midrst_quiet", cnt, 0);

`ifdef LED_SEQ_PAUSE_EN
        // Pause freezes GRAY; the next strobe arrives after the remaining count
        send_cmd(2'd1);
        wait_strobe(1'b0, n);
        check("pause_pre_gap", n, 8);
        check("pause_pre_leds", leds, 5'b00001);
        repeat (3) @(negedge clk);
        pause = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (step_strobe || leds != 5'b00001) cnt++;
        end
        check("pause_frozen", cnt, 0);
        pause = 1'b0;
        wait_strobe(1'b0, n);
        check("pause_resume_gap", n, 5);
        check("pause_resume_leds", leds, 5'b00011);
`endif

        // BREATHE on the slow instance: 32 clocks per level
        send_cmd_b(2'd3);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (leds_b != '0) cnt++;
        end
        check("breathe_level0_dark", cnt, 0);
        for (int k = 1; k <= 31; k++) begin
            wait_strobe(1'b1, n);
            check("breathe_gap", n, 16);
            lvl = (k <= 15) ? k : ((k <= 30) ? 30 - k : k - 30);
            full  = 0;
            mixed = 0;
            repeat (16) begin
                @(negedge clk);
                if (leds_b == 5'b11111) full++;
                else if (leds_b != 5'b00000) mixed++;
            end
            check("breathe_duty", full, lvl);
            check("breathe_all_bits", mixed, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
